// File: rtl/rgen_register_access_pkg.sv
// Shared types for the register access controller: FSM states and response status codes.
package rgen_register_access_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ACCESS   = 2'b01,
    RESPONSE = 2'b10
  } state_e;

  localparam logic [1:0] STATUS_OK           = 2'b00;
  localparam logic [1:0] STATUS_DECODE_ERROR = 2'b01;
  localparam logic [1:0] STATUS_TIMEOUT      = 2'b10;

endpackage

// File: rtl/rgen_address_match.sv
// Combinational decode of one register entry: address range, optional shadow index and
// direction permission must all agree for the entry to match.
module rgen_address_match #(
  parameter int                          ADDRESS_WIDTH      = 16,
  parameter int                          SHADOW_INDEX_WIDTH = 1,
  parameter logic [ADDRESS_WIDTH-1:0]      START_ADDRESS      = '0,
  parameter logic [ADDRESS_WIDTH-1:0]      END_ADDRESS        = '0,
  parameter logic                        READABLE           = 1'b1,
  parameter logic                        WRITABLE           = 1'b1,
  parameter logic                        USE_SHADOW_INDEX   = 1'b0,
  parameter logic [SHADOW_INDEX_WIDTH-1:0] SHADOW_INDEX_VALUE = '0
) (
  input  logic [ADDRESS_WIDTH-1:0]      i_address,
  input  logic [SHADOW_INDEX_WIDTH-1:0] i_shadow_index,
  input  logic                          i_write,
  output logic                          o_match
);

  logic above_start;
  logic below_end;
  logic shadow_ok;
  logic dir_ok;

  // A zero start bound is always satisfied; elaborate it away rather than compare against 0.
  if (START_ADDRESS == '0) begin : g_no_lo
    assign above_start = 1'b1;
  end else begin : g_lo
    assign above_start = (i_address >= START_ADDRESS);
  end

  assign below_end = (i_address <= END_ADDRESS);
  assign shadow_ok = !USE_SHADOW_INDEX || (i_shadow_index == SHADOW_INDEX_VALUE);
  assign dir_ok    = i_write ? WRITABLE : READABLE;
  assign o_match   = above_start && below_end && shadow_ok && dir_ok;

endmodule

// File: rtl/rgen_register_access_controller.sv
// Single-outstanding register access controller: decode, one-hot select, wait for ready, respond.
// Define RGEN_ACCESS_TIMEOUT_EN to bound the ACCESS wait by TIMEOUT_CYCLES.
module rgen_register_access_controller
  import rgen_register_access_pkg::*;
#(
  parameter int REGISTERS          = 4,
  parameter int ADDRESS_WIDTH      = 16,
  parameter int DATA_WIDTH         = 32,
  parameter int SHADOW_INDEX_WIDTH = 1,
  parameter logic [REGISTERS*ADDRESS_WIDTH-1:0]      START_ADDRESSES     = '0,
  parameter logic [REGISTERS*ADDRESS_WIDTH-1:0]      END_ADDRESSES       = '0,
  parameter logic [REGISTERS-1:0]                    READABLE            = '1,
  parameter logic [REGISTERS-1:0]                    WRITABLE            = '1,
  parameter logic [REGISTERS-1:0]                    USE_SHADOW_INDEX    = '0,
  parameter logic [REGISTERS*SHADOW_INDEX_WIDTH-1:0] SHADOW_INDEX_VALUES = '0,
  parameter int TIMEOUT_CYCLES     = 15
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_request_valid,
  output logic                            o_request_ready,
  input  logic                            i_write,
  input  logic [ADDRESS_WIDTH-1:0]        i_address,
  input  logic [SHADOW_INDEX_WIDTH-1:0]   i_shadow_index,
  input  logic [DATA_WIDTH-1:0]           i_write_data,
  output logic [REGISTERS-1:0]            o_select,
  output logic                            o_write,
  output logic [DATA_WIDTH-1:0]           o_write_data,
  input  logic [REGISTERS-1:0]            i_register_ready,
  input  logic [REGISTERS*DATA_WIDTH-1:0] i_register_read_data,
  output logic                            o_response_valid,
  input  logic                            i_response_ready,
  output logic [DATA_WIDTH-1:0]           o_read_data,
  output logic [1:0]                      o_status
);

  state_e                  state_q, state_d;
  logic [REGISTERS-1:0]    select_q, select_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              status_q, status_d;

  logic [REGISTERS-1:0]    match;
  logic [REGISTERS-1:0]    winner;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    sel_ready;
  logic                    timeout;

  for (genvar i = 0; i < REGISTERS; i++) begin : g_match
    rgen_address_match #(
      .ADDRESS_WIDTH      (ADDRESS_WIDTH),
      .SHADOW_INDEX_WIDTH (SHADOW_INDEX_WIDTH),
      .START_ADDRESS      (START_ADDRESSES[i*ADDRESS_WIDTH +: ADDRESS_WIDTH]),
      .END_ADDRESS        (END_ADDRESSES[i*ADDRESS_WIDTH +: ADDRESS_WIDTH]),
      .READABLE           (READABLE[i]),
      .WRITABLE           (WRITABLE[i]),
      .USE_SHADOW_INDEX   (USE_SHADOW_INDEX[i]),
      .SHADOW_INDEX_VALUE (SHADOW_INDEX_VALUES[i*SHADOW_INDEX_WIDTH +: SHADOW_INDEX_WIDTH])
    ) u_match (
      .i_address      (i_address),
      .i_shadow_index (i_shadow_index),
      .i_write        (i_write),
      .o_match        (match[i])
    );
  end

  // Scan high to low so the lowest matching index is the last writer and wins.
  always_comb begin
    winner = '0;
    for (int i = REGISTERS - 1; i >= 0; i--) begin
      if (match[i]) begin
        winner    = '0;
        winner[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < REGISTERS; i++) begin
      if (select_q[i]) sel_data = sel_data | i_register_read_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign sel_ready = |(i_register_ready & select_q);

`ifdef RGEN_ACCESS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Held at zero outside ACCESS, so entry into ACCESS always starts from a clean count.
  assign cnt_d   = (state_q == ACCESS) ? cnt_q + 1'b1 : '0;
  assign timeout = (state_q == ACCESS) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    select_d = select_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    status_d = status_q;
    unique case (state_q)
      IDLE: begin
        if (i_request_valid) begin
          write_d = i_write;
          wdata_d = i_write_data;
          if (|match) begin
            select_d = winner;
            state_d  = ACCESS;
          end else begin
            status_d = STATUS_DECODE_ERROR;
            rdata_d  = '0;
            state_d  = RESPONSE;
          end
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          rdata_d  = write_q ? '0 : sel_data;
          status_d = STATUS_OK;
          select_d = '0;
          state_d  = RESPONSE;
        end else if (timeout) begin
          rdata_d  = '0;
          status_d = STATUS_TIMEOUT;
          select_d = '0;
          state_d  = RESPONSE;
        end
      end
      RESPONSE: begin
        if (i_response_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      select_q <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      status_q <= STATUS_OK;
    end else begin
      state_q  <= state_d;
      select_q <= select_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
    end
  end

  assign o_request_ready  = (state_q == IDLE);
  assign o_response_valid = (state_q == RESPONSE);
  assign o_select         = select_q;
  assign o_write          = write_q;
  assign o_write_data     = wdata_q;
  assign o_read_data      = rdata_q;
  assign o_status         = status_q;

endmodule

// File: tb/tb_rgen_register_access_controller.sv
// Directed vector bench for rgen_register_access_controller with a four-entry decode map.
module tb_rgen_register_access_controller;

  localparam int REGS = 4;
  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int SW   = 1;

  logic                 i_clk = 1'b0;
  logic                 i_rst_n;
  logic                 i_request_valid;
  logic                 o_request_ready;
  logic                 i_write;
  logic [AW-1:0]        i_address;
  logic [SW-1:0]        i_shadow_index;
  logic [DW-1:0]        i_write_data;
  logic [REGS-1:0]      o_select;
  logic                 o_write;
  logic [DW-1:0]        o_write_data;
  logic [REGS-1:0]      i_register_ready;
  logic [REGS*DW-1:0]   i_register_read_data;
  logic                 o_response_valid;
  logic                 i_response_ready;
  logic [DW-1:0]        o_read_data;
  logic [1:0]           o_status;

  always #5 i_clk = ~i_clk;

  rgen_register_access_controller #(
    .REGISTERS          (REGS),
    .ADDRESS_WIDTH      (AW),
    .DATA_WIDTH         (DW),
    .SHADOW_INDEX_WIDTH (SW),
    .START_ADDRESSES    ({16'h0010, 16'h0010, 16'h0004, 16'h0000}),
    .END_ADDRESSES      ({16'h001F, 16'h001F, 16'h0007, 16'h0003}),
    .READABLE           (4'b1111),
    .WRITABLE           (4'b1110),
    .USE_SHADOW_INDEX   (4'b0100),
    .SHADOW_INDEX_VALUES(4'b0100),
    .TIMEOUT_CYCLES     (4)
  ) dut (
    .i_clk                (i_clk),
    .i_rst_n              (i_rst_n),
    .i_request_valid      (i_request_valid),
    .o_request_ready      (o_request_ready),
    .i_write              (i_write),
    .i_address            (i_address),
    .i_shadow_index       (i_shadow_index),
    .i_write_data         (i_write_data),
    .o_select             (o_select),
    .o_write              (o_write),
    .o_write_data         (o_write_data),
    .i_register_ready     (i_register_ready),
    .i_register_read_data (i_register_read_data),
    .o_response_valid     (o_response_valid),
    .i_response_ready     (i_response_ready),
    .o_read_data          (o_read_data),
    .o_status             (o_status)
  );

  // Fixed per-entry read data; entry 1 returns the recognisable pattern.
  localparam logic [DW-1:0] D0 = 32'hA000_0000;
  localparam logic [DW-1:0] D1 = 32'hDEAD_BEEF;
  localparam logic [DW-1:0] D2 = 32'hA000_0002;
  localparam logic [DW-1:0] D3 = 32'hA000_0003;
  assign i_register_read_data = {D3, D2, D1, D0};

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [SW-1:0] sh;
    logic [DW-1:0] wdata;
    int            delay;    // ACCESS cycle index in which ready is driven, -1 = never
    logic [3:0]    sel;      // expected select, 0 = decode error
    logic [1:0]    st;
    logic [DW-1:0] rdata;
    int            sel_cyc;
    int            bp;       // response backpressure cycles
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic pulse_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    i_request_valid = 1'b0;
    i_register_ready = '0;
    i_response_ready = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic run(input int idx, input vec_t t);
    int cyc, bad, unstable;
    bit done;
    logic [DW-1:0] rd_hold;
    logic [1:0]    st_hold;
    @(negedge i_clk);
    chk($sformatf("v%0d req_ready_idle", idx), o_request_ready, 1'b1);
    i_request_valid = 1'b1;
    i_write         = t.wr;
    i_address       = t.addr;
    i_shadow_index  = t.sh;
    i_write_data    = t.wdata;
    @(posedge i_clk);
    @(negedge i_clk);
    i_request_valid = 1'b0;
    if (t.sel == 4'b0000) begin
      chk($sformatf("v%0d decode_sel", idx), o_select, 4'b0000);
    end else begin
      chk($sformatf("v%0d o_write", idx), o_write, t.wr);
      chk($sformatf("v%0d o_write_data", idx), o_write_data, t.wdata);
      cyc = 0; bad = 0; done = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
        if (o_response_valid) done = 1'b1;
        else begin
          if (o_select === t.sel) cyc++;
          else bad++;
          // Other entries' ready bits toggle high while waiting and must be ignored.
          i_register_ready = (k == t.delay) ? t.sel : ~t.sel;
          @(posedge i_clk);
          @(negedge i_clk);
          i_register_ready = '0;
        end
      end
      chk($sformatf("v%0d response_within_bound", idx), done, 1'b1);
      if (!done) begin
        pulse_reset();
        return;
      end
      chk($sformatf("v%0d select_cycles", idx), cyc, t.sel_cyc);
      chk($sformatf("v%0d select_value", idx), bad, 0);
    end
    chk($sformatf("v%0d resp_valid", idx), o_response_valid, 1'b1);
    chk($sformatf("v%0d status", idx), o_status, t.st);
    chk($sformatf("v%0d read_data", idx), o_read_data, t.rdata);
    chk($sformatf("v%0d select_cleared", idx), o_select, 4'b0000);
    chk($sformatf("v%0d req_ready_busy", idx), o_request_ready, 1'b0);
    rd_hold = o_read_data;
    st_hold = o_status;
    unstable = 0;
    for (int b = 0; b < t.bp; b++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      if (!o_response_valid || o_request_ready || o_read_data !== rd_hold || o_status !== st_hold)
        unstable++;
    end
    if (t.bp > 0) chk($sformatf("v%0d backpressure_stable", idx), unstable, 0);
    i_response_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_response_ready = 1'b0;
    chk($sformatf("v%0d resp_done", idx), {o_response_valid, o_request_ready}, 2'b01);
  endtask

  initial begin
    //                wr    addr      sh    wdata          dly sel      status  rdata         cyc bp
    vecs.push_back('{1'b0, 16'h0004, 1'b0, 32'h0,         2, 4'b0010, 2'b00, D1,           3, 0});
    vecs.push_back('{1'b0, 16'h0040, 1'b0, 32'h0,         0, 4'b0000, 2'b01, 32'h0,        0, 0});
    vecs.push_back('{1'b1, 16'h0000, 1'b0, 32'hCAFE_F00D, 0, 4'b0000, 2'b01, 32'h0,        0, 0});
    vecs.push_back('{1'b0, 16'h0000, 1'b0, 32'h0,         0, 4'b0001, 2'b00, D0,           1, 0});
    vecs.push_back('{1'b0, 16'h0015, 1'b0, 32'h0,         1, 4'b1000, 2'b00, D3,           2, 0});
    vecs.push_back('{1'b0, 16'h0015, 1'b1, 32'h0,         0, 4'b0100, 2'b00, D2,           1, 0});
    vecs.push_back('{1'b1, 16'h001F, 1'b1, 32'h1234_5678, 0, 4'b0100, 2'b00, 32'h0,        1, 5});
    vecs.push_back('{1'b1, 16'h0006, 1'b0, 32'h5555_AAAA, 1, 4'b0010, 2'b00, 32'h0,        2, 0});
    vecs.push_back('{1'b0, 16'h0008, 1'b0, 32'h0,         0, 4'b0000, 2'b01, 32'h0,        0, 0});
    vecs.push_back('{1'b0, 16'h0003, 1'b0, 32'h0,         0, 4'b0001, 2'b00, D0,           1, 0});
    vecs.push_back('{1'b0, 16'h0020, 1'b1, 32'h0,         0, 4'b0000, 2'b01, 32'h0,        0, 3});
`ifdef RGEN_ACCESS_TIMEOUT_EN
    vecs.push_back('{1'b0, 16'h0010, 1'b0, 32'h0,        -1, 4'b1000, 2'b10, 32'h0,        4, 0});
    vecs.push_back('{1'b0, 16'h0010, 1'b0, 32'h0,         3, 4'b1000, 2'b00, D3,           4, 0});
`else
    vecs.push_back('{1'b0, 16'h0010, 1'b0, 32'h0,        10, 4'b1000, 2'b00, D3,          11, 0});
`endif

    i_rst_n          = 1'b0;
    i_request_valid  = 1'b0;
    i_write          = 1'b0;
    i_address        = '0;
    i_shadow_index   = '0;
    i_write_data     = '0;
    i_register_ready = '0;
    i_response_ready = 1'b0;
    #12;
    chk("reset req_ready", o_request_ready, 1'b1);
    chk("reset outputs", {o_select, o_write, o_write_data, o_response_valid, o_read_data, o_status},
        '0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    foreach (vecs[i]) run(i, vecs[i]);

    // Reset in the middle of ACCESS drops the transaction without a response.
    @(negedge i_clk);
    i_request_valid = 1'b1;
    i_write         = 1'b1;
    i_address       = 16'h0005;
    i_shadow_index  = 1'b0;
    i_write_data    = 32'h0BAD_0BAD;
    @(posedge i_clk);
    @(negedge i_clk);
    i_request_valid = 1'b0;
    chk("midreset select_before", o_select, 4'b0010);
    i_rst_n = 1'b0;
    #1;
    chk("midreset outputs", {o_select, o_write, o_write_data, o_response_valid, o_read_data, o_status},
        '0);
    chk("midreset req_ready", o_request_ready, 1'b1);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_register_ready = 4'b1111;
    @(posedge i_clk);
    @(negedge i_clk);
    i_register_ready = '0;
    repeat (2) begin
      @(posedge i_clk);
      @(negedge i_clk);
    end
    chk("midreset no_response", {o_response_valid, o_select, o_request_ready}, {1'b0, 4'b0000, 1'b1});

    // Clean transaction after the reset confirms the controller recovered.
    run(99, '{1'b0, 16'h0007, 1'b0, 32'h0, 0, 4'b0010, 2'b00, D1, 1, 0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/rgen_register_access_controller.md
# rgen_register_access_controller

Multi-register decode-and-access controller for generated register blocks. Accepts one host request at a time over a valid/ready handshake and decodes it against a parameterised table of REGISTERS entries (address range, shadow index, access permissions). It drives a registered one-hot select and then waits for the selected register's ready. It returns a response with status (OK, decode error, timeout) over a second valid/ready handshake. It sits between the host bus bridge and the per-register field logic.

## Interface
Parameters:
- REGISTERS, 4: number of decoded entries, ≥1
- ADDRESS_WIDTH, 16: request address width
- DATA_WIDTH, 32: data width
- SHADOW_INDEX_WIDTH, 1: shadow index width
- START_ADDRESSES, 0: packed REGISTERS×ADDRESS_WIDTH; entry i occupies slice i
- END_ADDRESSES, 0: packed, inclusive end address; END ≥ START per entry
- READABLE, all-1: REGISTERS bits; bit i permits reads of entry i
- WRITABLE, all-1: REGISTERS bits; bit i permits writes of entry i
- USE_SHADOW_INDEX, 0: REGISTERS bits; bit i enables shadow compare for entry i
- SHADOW_INDEX_VALUES, 0: packed REGISTERS×SHADOW_INDEX_WIDTH
- TIMEOUT_CYCLES, 15: ACCESS cycles before timeout, ≥1

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - i_clk  input  1  clock
  - i_rst_n  input  1  asynchronous active-low reset
- Request channel:
  - i_request_valid  input  1  request present
  - o_request_ready  output  1  controller idle; request accepted when valid&&ready
  - i_write  input  1  1=write, 0=read
  - i_address  input  ADDRESS_WIDTH  request address
  - i_shadow_index  input  SHADOW_INDEX_WIDTH  request shadow index
  - i_write_data  input  DATA_WIDTH  write data
- Register side:
  - o_select  output  REGISTERS  one-hot register select, registered
  - o_write  output  1  captured direction
  - o_write_data  output  DATA_WIDTH  captured write data
  - i_register_ready  input  REGISTERS  per-register access completion
  - i_register_read_data  input  REGISTERS×DATA_WIDTH  packed read data
- Response channel:
  - o_response_valid  output  1  response present
  - i_response_ready  input  1  host accepts response
  - o_read_data  output  DATA_WIDTH  read data; 0 for writes and errors
  - o_status  output  2  00 OK, 01 DECODE_ERROR, 10 TIMEOUT

## Operation
- Entry i matches when all three hold:
  - START_i ≤ i_address ≤ END_i.
  - The shadow index equals SHADOW_INDEX_VALUES_i, or USE_SHADOW_INDEX[i]=0.
  - The direction is permitted: READABLE[i] for reads, WRITABLE[i] for writes.
- On overlapping matches, the lowest index wins.
- FSM states IDLE, ACCESS, RESPONSE. o_request_ready = (state==IDLE).
- IDLE, on accept:
  - Capture o_write and o_write_data.
  - Any match: o_select ← one-hot of the winning entry; go to ACCESS.
  - No match: o_status ← 01, o_read_data ← 0; go to RESPONSE.
- ACCESS, when i_register_ready of the selected entry is high:
  - Capture the read data, or 0 on writes; o_status ← 00.
  - Clear o_select; go to RESPONSE.
  - Ready bits of unselected entries are ignored.
- ACCESS timeout: the counter reaches TIMEOUT_CYCLES with no ready. o_status ← 10, o_read_data ← 0, clear o_select, go to RESPONSE.
- RESPONSE: o_response_valid=1; data and status are held stable until i_response_ready, then go to IDLE.
- Reset values:
  - state IDLE, so o_request_ready reads 1 during and after reset.
  - o_select 0, o_write 0, o_write_data 0.
  - o_response_valid 0, o_read_data 0, o_status 00, counter 0.

## Timing
- Accept at edge N → o_select high from cycle N+1.
- Ready sampled high at edge K → o_response_valid from cycle K+1. The minimum OK-path latency is 2 cycles.
- Decode error → o_response_valid in cycle N+1; o_select never asserts.
- Timeout counter:
  - Width $clog2(TIMEOUT_CYCLES+1).
  - Cleared on entry to ACCESS; increments each ACCESS cycle.
  - Timeout fires in the cycle the counter equals TIMEOUT_CYCLES−1 with ready low. o_select is then high for exactly TIMEOUT_CYCLES cycles.
- Ready and timeout in the same cycle: ready wins, status OK.
- i_response_ready high at the RESPONSE edge: return to IDLE. A back-to-back request can be accepted in the following cycle, never in the same cycle.
- Reset mid-ACCESS or mid-RESPONSE: immediate return to reset values. No response is issued.

## Configuration
- RGEN_ACCESS_TIMEOUT_EN defined: the timeout counter and status 10 behave as above.
- Not defined:
  - The counter is not instantiated and TIMEOUT_CYCLES is ignored.
  - ACCESS waits indefinitely for ready, so status 10 never occurs.

## Structure
- Package rgen_register_access_pkg holds:
  - The state enum (IDLE, ACCESS, RESPONSE).
  - Status constants STATUS_OK, STATUS_DECODE_ERROR, STATUS_TIMEOUT, each 2 bits.
- Sub-module rgen_address_match, generated once per entry, is purely combinational. It does the range, shadow and permission compare and outputs 1 match bit.
- The top level holds the priority encoder, FSM, counter and data capture.

## Test plan
- Read OK: entry 1 at 0x04, read 0x04, ready after 2 cycles with data 0xDEADBEEF → o_select=0010 for 3 cycles; response OK with 0xDEADBEEF.
- Decode error: read 0x40, no entry covers it → response in cycle N+1 with status 01, data 0; o_select stays 0.
- Permission: entry 0 read-only, write to its address → DECODE_ERROR; a read of the same address returns OK.
- Overlap/shadow:
  - Entries 2 and 3 both span 0x10–0x1F, entry 2 shadow 1 → index 0 selects 1000.
  - Index 1 selects 0100.
- Timeout (RGEN_ACCESS_TIMEOUT_EN, TIMEOUT_CYCLES=4):
  - Ready never asserted → o_select high 4 cycles, status 10.
  - Ready in the 4th cycle → status OK.
- Backpressure/reset:
  - i_response_ready held low 5 cycles → response stable, o_request_ready=0.
  - i_rst_n asserted mid-ACCESS → all outputs return to reset values, no response.
